// File: rtl/sub_cla_pipe.sv
// sub_cla_pipe: two-stage pipelined carry-lookahead subtractor, diff = a + ~b + 1.
// Stage 1 forms bit generate/propagate and per-group lookahead terms.
// Stage 2 resolves the carries and produces the difference, borrow, zero and overflow.
//
// Handshake (both sides): a transfer happens on a rising edge where valid & ready
// are both 1. A source holds its data and valid stable until that transfer.
// Ready never depends on the valid it is paired with; in_ready depends
// combinationally on out_ready so that a full pipe can still accept every cycle.
module sub_cla_pipe #(
  parameter int WIDTH = 26,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_ovf
);

  // Number of lookahead groups; the last one may be narrower than GROUP.
  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  // Pipeline control.
  logic out_adv;
  logic s1_adv;
  logic accept;
  logic s1_valid;

  // Stage 1 combinational terms.
  logic [WIDTH-1:0] b_n;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic [NG-1:0]    gg1;
  logic [NG-1:0]    gp1;

  // Stage 1 registers.
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [NG-1:0]    s1_gg;
  logic [NG-1:0]    s1_gp;
  logic             s1_a_msb;
  logic             s1_b_msb;

  // Stage 2 combinational terms.
  logic [NG:0]      gc2;
  logic [WIDTH:0]   c2;
  logic [WIDTH-1:0] diff2;
  logic             borrow2;
  logic             zero2;
  logic             ovf2;

  assign out_adv  = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | out_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & in_ready;

  assign b_n = ~in_b;
  assign g1  = in_a & b_n;
  assign p1  = in_a ^ b_n;

  // First-level lookahead: fold each group's bits, LSB first, into group G/P.
  always_comb begin
    gg1 = '0;
    gp1 = '1;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        if (k * GROUP + j < WIDTH) begin
          gg1[k] = g1[k * GROUP + j] | (p1[k * GROUP + j] & gg1[k]);
          gp1[k] = gp1[k] & p1[k * GROUP + j];
        end
      end
    end
  end

  // Stage 1 register: captures lookahead terms and operand sign bits on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_gg    <= '0;
      s1_gp    <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_g     <= g1;
        s1_p     <= p1;
        s1_gg    <= gg1;
        s1_gp    <= gp1;
        s1_a_msb <= in_a[WIDTH-1];
        s1_b_msb <= in_b[WIDTH-1];
      end
    end
  end

  // Second-level lookahead across groups (carry-in 1 completes the two's
  // complement), then per-bit carries expanded inside each group. The top bit
  // of a group also ripples a carry-out, but the group-level carry replaces
  // it at the next boundary and at the final carry-out.
  always_comb begin
    gc2    = '0;
    c2     = '0;
    gc2[0] = 1'b1;
    for (int k = 0; k < NG; k++) begin
      gc2[k + 1] = s1_gg[k] | (s1_gp[k] & gc2[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c2[k * GROUP] = gc2[k];
      for (int j = 0; j < GROUP; j++) begin
        if (k * GROUP + j < WIDTH) begin
          c2[k * GROUP + j + 1] = s1_g[k * GROUP + j] |
                                  (s1_p[k * GROUP + j] & c2[k * GROUP + j]);
        end
      end
    end
    c2[WIDTH] = gc2[NG];
  end

  assign diff2   = s1_p ^ c2[WIDTH-1:0];
  assign borrow2 = ~c2[WIDTH];
  assign zero2   = ~|diff2;
  assign ovf2    = (s1_a_msb ^ s1_b_msb) & (diff2[WIDTH-1] ^ s1_a_msb);

  // Output register: loads a new result when the slot is free or being drained;
  // data is only overwritten by a real result so it holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_diff   <= diff2;
        out_borrow <= borrow2;
        out_zero   <= zero2;
        out_ovf    <= ovf2;
      end
    end
  end

endmodule

// File: tb/tb_sub_cla_pipe.sv
// tb_sub_cla_pipe: directed checks for sub_cla_pipe at WIDTH=26, GROUP=4.
// Expected results are hand-computed constants packed as {diff, borrow, zero, ovf}.
module tb_sub_cla_pipe;

  localparam int WIDTH = 26;
  localparam int GROUP = 4;
  localparam int W     = WIDTH + 3;
  localparam int NV    = 11;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_zero;
  logic             out_ovf;

  int vectors;
  int miscompares;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pending_exp;
  logic         acc_last;
  logic         rand_ready;

  // Directed vector table: a, b, {diff, borrow, zero, ovf}.
  logic [WIDTH-1:0] tab_a [0:NV-1] = '{26'h0000005, 26'h0000003, 26'h0000000, 26'h2AAAAAA,
                                       26'h2000000, 26'h1FFFFFF, 26'h3FFFFFF, 26'h0000000,
                                       26'h1555555, 26'h000000F, 26'h0000010};
  logic [WIDTH-1:0] tab_b [0:NV-1] = '{26'h0000003, 26'h0000005, 26'h0000001, 26'h2AAAAAA,
                                       26'h0000001, 26'h3FFFFFF, 26'h0000000, 26'h2000000,
                                       26'h0AAAAAA, 26'h0000010, 26'h000000F};
  logic [W-1:0]     tab_e [0:NV-1] = '{{26'h0000002, 3'b000}, {26'h3FFFFFE, 3'b100},
                                       {26'h3FFFFFF, 3'b100}, {26'h0000000, 3'b010},
                                       {26'h1FFFFFF, 3'b001}, {26'h2000000, 3'b101},
                                       {26'h3FFFFFF, 3'b000}, {26'h2000000, 3'b101},
                                       {26'h0AAAAAB, 3'b000}, {26'h3FFFFFF, 3'b100},
                                       {26'h0000001, 3'b000}};

  sub_cla_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: score an output transfer, record an input accept, move to next negedge.
  task automatic step();
    logic [W-1:0] e;
    logic         acc;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_diff",   {6'd0, out_diff},   {6'd0, e[W-1:3]});
        check("sb_borrow", {31'd0, out_borrow}, {31'd0, e[2]});
        check("sb_zero",   {31'd0, out_zero},   {31'd0, e[1]});
        check("sb_ovf",    {31'd0, out_ovf},    {31'd0, e[0]});
      end
    end
    acc = in_valid && in_ready && !rst;
    if (acc) exp_q.push_back(pending_exp);
    acc_last = acc;
    @(negedge clk);
  endtask

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [W-1:0] exp);
    int tries;
    in_valid    = 1'b1;
    in_a        = a;
    in_b        = b;
    pending_exp = exp;
    tries       = 0;
    do begin
      step();
      tries++;
    end while (!acc_last && tries < 64);
    check("accept_in_time", {31'd0, acc_last}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_idx(input int i);
    send(tab_a[i], tab_b[i], tab_e[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    rand_ready  = 1'b0;
    pending_exp = '0;
    acc_last    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_diff",  {6'd0, out_diff},   32'd0);
    check("rst_flags",     {29'd0, out_borrow, out_zero, out_ovf}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);

    // Basic 5-3 with exact latency.
    out_ready = 1'b1;
    send(26'h0000005, 26'h0000003, {26'h0000002, 3'b000});
    check("lat_after_1_edge_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_after_2_edges_valid", {31'd0, out_valid}, 32'd1);
    check("lat_diff", {6'd0, out_diff}, 32'h0000002);
    check("lat_flags", {29'd0, out_borrow, out_zero, out_ovf}, 32'd0);
    step();

    // Directed table back-to-back at full throughput.
    for (int i = 0; i < NV; i++) send_idx(i);
    repeat (4) step();
    check("table_drained", exp_q.size(), 32'd0);

    // Backpressure: two accepts then in_ready drops, output holds first result.
    out_ready = 1'b0;
    send(26'h0000064, 26'h0000001, {26'h0000063, 3'b000});
    send(26'h1234567, 26'h0234567, {26'h1000000, 3'b000});
    in_valid    = 1'b1;
    in_a        = 26'h0000010;
    in_b        = 26'h0000020;
    pending_exp = {26'h3FFFFF0, 3'b100};
    #1;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_diff_0", {6'd0, out_diff}, 32'h0000063);
    step();
    step();
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    check("bp_hold_diff_2", {6'd0, out_diff}, 32'h0000063);
    check("bp_hold_valid_2", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    send(26'h0000010, 26'h0000020, {26'h3FFFFF0, 3'b100});
    send(26'h3FFFFFF, 26'h3FFFFFF, {26'h0000000, 3'b010});
    step();
    step();
    check("bp_done_valid", {31'd0, out_valid}, 32'd0);
    check("bp_drained", exp_q.size(), 32'd0);

    // Reset mid-operation: both in-flight results are discarded.
    out_ready = 1'b0;
    send(26'h0000003, 26'h0000005, {26'h3FFFFFE, 3'b100});
    send(26'h2AAAAAA, 26'h2AAAAAA, {26'h0000000, 3'b010});
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_diff",  {6'd0, out_diff},   32'd0);
    check("midrst_flags",     {29'd0, out_borrow, out_zero, out_ovf}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check("midrst_no_ghost_valid", {31'd0, out_valid}, 32'd0);
    send(26'h0000009, 26'h0000004, {26'h0000005, 3'b000});
    check("post_rst_lat1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_diff", {6'd0, out_diff}, 32'h0000005);
    step();

    // Table replayed with random gaps and random downstream stalls.
    rand_ready = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NV; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send_idx(i);
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    step();
    check("random_drained", exp_q.size(), 32'd0);
    check("random_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
